// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, host command bytes and default timing.
package ps2_pkg;

  localparam int PS2_INHIBIT_CYCLES_DEF = 5000;
  localparam int PS2_FILTER_LEN_DEF     = 8;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RTS   = 3'd1,
    S_START = 3'd2,
    S_DATA  = 3'd3,
    S_STOP  = 3'd4,
    S_ACK   = 3'd5,
    S_DONE  = 3'd6
  } ps2_tx_state_e;

  function automatic logic ps2_odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Request, line readback and status signals of the PS/2 host transmitter.
interface ps2_host_tx_if;
  logic       wr_ps2;
  logic [7:0] din;
  logic       ps2c_in;
  logic       ps2d_in;
  logic       ps2c_oe;
  logic       ps2d_oe;
  logic       tx_idle;
  logic       tx_done_tick;
  logic       ack_err;

  modport master (
    output wr_ps2, din, ps2c_in, ps2d_in,
    input  ps2c_oe, ps2d_oe, tx_idle, tx_done_tick, ack_err
  );

  modport slave (
    input  wr_ps2, din, ps2c_in, ps2d_in,
    output ps2c_oe, ps2d_oe, tx_idle, tx_done_tick, ack_err
  );
endinterface

// File: rtl/ps2_clk_filter.sv
// Synchronises the PS/2 clock/data pins and debounces the clock into a one-cycle falling-edge pulse.
module ps2_clk_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = PS2_FILTER_LEN_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic i_ps2c,
  input  logic i_ps2d,
  output logic o_fall,
  output logic o_ps2d_s
);

  logic [1:0]            r_c_sync;
  logic [1:0]            r_d_sync;
  logic [FILTER_LEN-1:0] r_shift;
  logic                  r_c_filt;
  logic                  r_fall;
  logic                  w_c_filt_nxt;

  // Filtered clock only moves once the whole window agrees; mixed windows hold.
  always_comb begin
    w_c_filt_nxt = r_c_filt;
    if (&r_shift)
      w_c_filt_nxt = 1'b1;
    else if (~|r_shift)
      w_c_filt_nxt = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_c_sync <= 2'b11;
      r_d_sync <= 2'b11;
      r_shift  <= '1;
      r_c_filt <= 1'b1;
      r_fall   <= 1'b0;
    end else begin
      r_c_sync <= {r_c_sync[0], i_ps2c};
      r_d_sync <= {r_d_sync[0], i_ps2d};
      r_shift  <= {r_shift[FILTER_LEN-2:0], r_c_sync[1]};
      r_c_filt <= w_c_filt_nxt;
      r_fall   <= r_c_filt & ~w_c_filt_nxt;
    end
  end

  assign o_fall   = r_fall;
  assign o_ps2d_s = r_d_sync[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: IDLE -> RTS (clock inhibit) -> START -> DATA x9 -> STOP [-> ACK] -> DONE.
// Optional device-acknowledge checking is enabled by defining PS2_HOST_TX_ACK_CHECK_EN.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES_DEF,
  parameter int FILTER_LEN     = PS2_FILTER_LEN_DEF
) (
  input logic           clk,
  input logic           reset,
  ps2_host_tx_if.slave  bus
);

  localparam int CNT_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;

  localparam logic [2:0] ST_IDLE  = S_IDLE;
  localparam logic [2:0] ST_RTS   = S_RTS;
  localparam logic [2:0] ST_START = S_START;
  localparam logic [2:0] ST_DATA  = S_DATA;
  localparam logic [2:0] ST_STOP  = S_STOP;
  localparam logic [2:0] ST_DONE  = S_DONE;
`ifdef PS2_HOST_TX_ACK_CHECK_EN
  localparam logic [2:0] ST_ACK   = S_ACK;
`endif

  logic [2:0]       r_state, w_state_nxt;
  logic [8:0]       r_b, w_b_nxt;
  logic [3:0]       r_n, w_n_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_ps2c_oe, r_ps2d_oe, r_tx_idle, r_tx_done_tick;
  logic             w_fall, w_ps2d_s;

  ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk      (clk),
    .reset    (reset),
    .i_ps2c   (bus.ps2c_in),
    .i_ps2d   (bus.ps2d_in),
    .o_fall   (w_fall),
    .o_ps2d_s (w_ps2d_s)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_b_nxt     = r_b;
    w_n_nxt     = r_n;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE:
        if (bus.wr_ps2) begin
          w_state_nxt = ST_RTS;
          w_b_nxt     = {ps2_odd_parity(bus.din), bus.din};
          w_cnt_nxt   = CNT_W'(INHIBIT_CYCLES - 1);
        end
      ST_RTS:
        if (r_cnt == '0) w_state_nxt = ST_START;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      ST_START:
        if (w_fall) begin
          w_state_nxt = ST_DATA;
          w_n_nxt     = 4'd8;
        end
      ST_DATA:
        if (w_fall) begin
          w_b_nxt = {1'b0, r_b[8:1]};
          if (r_n == 4'd0) w_state_nxt = ST_STOP;
          else             w_n_nxt     = r_n - 4'd1;
        end
      ST_STOP:
`ifdef PS2_HOST_TX_ACK_CHECK_EN
        if (w_fall) w_state_nxt = ST_ACK;
      ST_ACK:
        if (w_fall) w_state_nxt = ST_DONE;
`else
        if (w_fall) w_state_nxt = ST_DONE;
`endif
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_b            <= '0;
      r_n            <= '0;
      r_cnt          <= '0;
      r_ps2c_oe      <= 1'b0;
      r_ps2d_oe      <= 1'b0;
      r_tx_idle      <= 1'b1;
      r_tx_done_tick <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_b            <= w_b_nxt;
      r_n            <= w_n_nxt;
      r_cnt          <= w_cnt_nxt;
      r_ps2c_oe      <= (w_state_nxt == ST_RTS);
      r_ps2d_oe      <= (w_state_nxt == ST_START) |
                        ((w_state_nxt == ST_DATA) & ~w_b_nxt[0]);
      r_tx_idle      <= (w_state_nxt == ST_IDLE);
      r_tx_done_tick <= (w_state_nxt == ST_DONE);
    end
  end

`ifdef PS2_HOST_TX_ACK_CHECK_EN
  logic r_ack_err;

  always_ff @(posedge clk) begin
    if (reset)
      r_ack_err <= 1'b0;
    else if (r_state == ST_IDLE && bus.wr_ps2)
      r_ack_err <= 1'b0;
    else if (r_state == ST_ACK && w_fall && w_ps2d_s)
      r_ack_err <= 1'b1;
  end

  assign bus.ack_err = r_ack_err;
`else
  logic w_unused_ps2d;
  assign w_unused_ps2d = w_ps2d_s;
  assign bus.ack_err   = 1'b0;
`endif

  assign bus.ps2c_oe      = r_ps2c_oe;
  assign bus.ps2d_oe      = r_ps2d_oe;
  assign bus.tx_idle      = r_tx_idle;
  assign bus.tx_done_tick = r_tx_done_tick;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out and checks them against a scoreboard queue.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INHIBIT = 20;
  localparam int FLEN    = 8;
  localparam int HALF    = 50;
`ifdef PS2_HOST_TX_ACK_CHECK_EN
  localparam logic ACK_EN = 1'b1;
`else
  localparam logic ACK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic dev_c = 1'b1;
  logic dev_d = 1'b1;

  always #5 clk = ~clk;

  ps2_host_tx_if bus();

  // Open-drain lines: low if either side pulls.
  assign bus.ps2c_in = dev_c & ~bus.ps2c_oe;
  assign bus.ps2d_in = dev_d & ~bus.ps2d_oe;

  ps2_host_tx #(.INHIBIT_CYCLES(INHIBIT), .FILTER_LEN(FLEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_ticks  = 0;
  int   rts_run  = 0;
  logic exp_q[$];

  typedef struct {
    logic [7:0] din;
    logic       drive_ack;
    int         wr_at;
    logic       exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inhibit length and RTS->START handover are checked whenever the clock pull ends.
  always @(negedge clk) begin
    if (reset) begin
      rts_run = 0;
    end else begin
      if (bus.tx_done_tick) n_ticks++;
      if (bus.ps2c_oe) begin
        rts_run++;
      end else if (rts_run != 0) begin
        check("inhibit_len", rts_run, INHIBIT);
        check("rts_start_handover", {31'b0, bus.ps2d_oe}, 1);
        rts_run = 0;
      end
    end
  end

  task automatic do_write(input logic [7:0] d, input logic accepted);
    int ones;
    @(negedge clk);
    bus.din    = d;
    bus.wr_ps2 = 1'b1;
    @(negedge clk);
    bus.wr_ps2 = 1'b0;
    if (accepted) begin
      check("wr_idle_low", {31'b0, bus.tx_idle}, 0);
      check("wr_c_oe", {31'b0, bus.ps2c_oe}, 1);
      check("wr_ack_clear", {31'b0, bus.ack_err}, 0);
      ones = 0;
      exp_q.push_back(1'b0);
      for (int i = 0; i < 8; i++) begin
        exp_q.push_back(d[i]);
        if (d[i]) ones++;
      end
      exp_q.push_back((ones % 2) == 0);
      exp_q.push_back(1'b1);
    end
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (bus.ps2d_oe && !bus.ps2c_oe) ok = 1'b1;
    end
    if (!ok) check("start_timeout", 0, 1);
  endtask

  // Device generates n_falls clock pulses, reading the data line at each falling edge.
  task automatic dev_clocks(input int n_falls, input logic drive_ack, input int wr_at);
    logic e;
    for (int f = 1; f <= n_falls; f++) begin
      repeat (HALF) @(negedge clk);
      dev_c = 1'b0;
      if (f <= 11) begin
        if (exp_q.size() == 0) begin
          check("frame_underflow", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("frame_bit%0d", f), {31'b0, bus.ps2d_in}, {31'b0, e});
        end
      end
      if (f == 11 && drive_ack) dev_d = 1'b0;
      if (f == wr_at) do_write(PS2_CMD_RESET, 1'b0);
      repeat (HALF) @(negedge clk);
      dev_c = 1'b1;
      if (f == 12) dev_d = 1'b1;
    end
  endtask

  task automatic end_check(input logic exp_err, input int ticks_before);
    repeat (30) @(negedge clk);
    check("done_ticks", n_ticks - ticks_before, 1);
    check("ack_err", {31'b0, bus.ack_err}, {31'b0, exp_err});
    check("idle_after", {31'b0, bus.tx_idle}, 1);
    check("oe_released", {30'b0, bus.ps2c_oe, bus.ps2d_oe}, 0);
    check("queue_empty", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic full_xfer(input logic [7:0] d, input logic drive_ack, input int wr_at,
                           input logic exp_err);
    int t0;
    bit ok;
    t0 = n_ticks;
    do_write(d, 1'b1);
    wait_start(ok);
    if (ok) begin
      dev_clocks(12, drive_ack, wr_at);
      end_check(exp_err, t0);
    end else begin
      exp_q.delete();
    end
  endtask

  initial begin
    int t0;
    bit ok;
    vecs[0] = '{PS2_CMD_SET_LED, 1'b1, 0, 1'b0};
    vecs[1] = '{8'h00,           1'b1, 0, 1'b0};
    vecs[2] = '{8'h01,           1'b1, 0, 1'b0};
    vecs[3] = '{8'hA5,           1'b0, 0, ACK_EN};
    vecs[4] = '{PS2_CMD_ENABLE,  1'b1, 0, 1'b0};
    vecs[5] = '{PS2_CMD_SET_LED, 1'b1, 4, 1'b0};

    reset      = 1'b1;
    bus.wr_ps2 = 1'b0;
    bus.din    = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_c_oe", {31'b0, bus.ps2c_oe}, 0);
    check("rst_d_oe", {31'b0, bus.ps2d_oe}, 0);
    check("rst_idle", {31'b0, bus.tx_idle}, 1);
    check("rst_tick", {31'b0, bus.tx_done_tick}, 0);
    check("rst_ack_err", {31'b0, bus.ack_err}, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 6; i++)
      full_xfer(vecs[i].din, vecs[i].drive_ack, vecs[i].wr_at, vecs[i].exp_err);

    // Reset in the middle of DATA, after the fourth data bit has gone out.
    t0 = n_ticks;
    do_write(PS2_CMD_SET_LED, 1'b1);
    wait_start(ok);
    if (ok) dev_clocks(5, 1'b1, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_c_oe", {31'b0, bus.ps2c_oe}, 0);
    check("midrst_d_oe", {31'b0, bus.ps2d_oe}, 0);
    check("midrst_idle", {31'b0, bus.tx_idle}, 1);
    reset = 1'b0;
    exp_q.delete();
    repeat (20) @(negedge clk);
    check("midrst_no_tick", n_ticks - t0, 0);
    full_xfer(PS2_CMD_ENABLE, 1'b1, 0, 1'b0);

    // Short clock glitches while in START must not advance the frame.
    t0 = n_ticks;
    do_write(8'h01, 1'b1);
    wait_start(ok);
    if (ok) begin
      repeat (30) @(negedge clk);
      repeat (3) begin
        dev_c = 1'b0;
        repeat (3) @(negedge clk);
        dev_c = 1'b1;
        repeat (6) @(negedge clk);
      end
      repeat (20) @(negedge clk);
      check("glitch_hold_d_oe", {31'b0, bus.ps2d_oe}, 1);
      check("glitch_hold_c_oe", {31'b0, bus.ps2c_oe}, 0);
      dev_clocks(12, 1'b1, 0);
      end_check(1'b0, t0);
    end else begin
      exp_q.delete();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
